// File: rtl/ir_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ir_frame_buffer
// Description : Double-buffered COLSxROWS 8-bit IR frame store.
//               A complete frame is captured into the back bank. The banks
//               then swap in a single cycle, so the display never sees a
//               partial frame. A 2-stage scaled read port (nearest-neighbour
//               upscale by 2**SCALE_SHIFT) serves the display timing stage.
//
//               Ports:
//                 clk100M      system clock
//                 rst          synchronous active-high reset
//                 frame_start  strobe: next pixel is pixel 0 of a new frame
//                 pix_valid    strobe: pix_data holds next raster pixel
//                 pix_data     pixel value
//                 rd_en        read request (rd_x, rd_y display coordinates)
//                 rd_valid     rd_en delayed by 2 cycles
//                 rd_data      pixel at (rd_x>>SCALE_SHIFT, rd_y>>SCALE_SHIFT)
//                 frame_ready  1-cycle pulse on each bank swap
//                 frame_count  completed frames (wrapping)
//                 drop_count   aborted short frames (saturating)
//
//               Build option: FRAME_MIRROR_EN mirrors the write column
//               (COLS-1-col) for a rear-mounted sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_frame_buffer #(
  parameter int COLS        = 32,
  parameter int ROWS        = 24,
  parameter int SCALE_SHIFT = 3
) (
  input  logic        clk100M,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic        rd_en,
  input  logic [8:0]  rd_x,
  input  logic [8:0]  rd_y,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        frame_ready,
  output logic [15:0] frame_count,
  output logic [7:0]  drop_count
);

  localparam int              c_CW      = $clog2(COLS);
  localparam int              c_RW      = $clog2(ROWS);
  localparam int              c_AW      = c_CW + c_RW;
  localparam int              c_DEPTH   = COLS * ROWS;
  localparam logic [c_AW-1:0] c_LAST    = c_AW'(c_DEPTH - 1);
  localparam logic [8:0]      c_COLS9   = 9'(COLS);
  localparam logic [8:0]      c_ROWS9   = 9'(ROWS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } wr_state_t;

  wr_state_t       r_state, w_state_nxt;
  logic [c_AW-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [c_AW-1:0] w_pix_idx;
  logic [c_AW-1:0] w_ram_waddr;
  logic [c_CW-1:0] w_wr_col;
  logic            w_active, w_we, w_last, w_drop;

  logic            r_disp_bank, r_have_frame, r_frame_ready;
  logic [15:0]     r_frame_count;
  logic [7:0]      r_drop_count;

  logic [7:0]      r_mem [0:1][0:c_DEPTH-1];

  // -------------------------------------------------------------------------
  // Write FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_wr_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_addr <= w_wr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_addr_nxt = r_wr_addr;
    w_last        = 1'b0;
    // frame_start takes effect before a coincident pixel, which then
    // becomes pixel 0 of the new frame.
    w_active      = frame_start || (r_state == ST_FILL);
    w_pix_idx     = frame_start ? '0 : r_wr_addr;
    w_we          = pix_valid && w_active;
    // While filling, every frame_start aborts a frame that cannot yet be
    // complete (the last pixel returns the FSM to IDLE).
    w_drop        = frame_start && (r_state == ST_FILL);
    if (w_active) begin
      w_state_nxt   = ST_FILL;
      w_wr_addr_nxt = w_pix_idx;
    end
    if (w_we) begin
      if (w_pix_idx == c_LAST) begin
        w_last        = 1'b1;
        w_state_nxt   = ST_IDLE;
        w_wr_addr_nxt = '0;
      end else begin
        w_wr_addr_nxt = w_pix_idx + 1'b1;
      end
    end
  end

`ifdef FRAME_MIRROR_EN
  assign w_wr_col = c_CW'(COLS - 1) - w_pix_idx[c_CW-1:0];
`else
  assign w_wr_col = w_pix_idx[c_CW-1:0];
`endif

  assign w_ram_waddr = {w_pix_idx[c_AW-1:c_CW], w_wr_col};

  // Bank swap and frame statistics
  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_disp_bank   <= 1'b0;
      r_have_frame  <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_frame_ready <= w_last;
      if (w_last) begin
        r_disp_bank   <= ~r_disp_bank;
        r_have_frame  <= 1'b1;
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline
  // -------------------------------------------------------------------------
  logic [8:0]      w_rd_col, w_rd_row;
  logic            w_rd_oor;
  logic [c_AW-1:0] w_rd_addr;

  logic            r_s1_valid, r_s1_zero, r_s1_bank;
  logic [c_AW-1:0] r_s1_addr;
  logic            r_s2_valid, r_s2_zero;
  logic [7:0]      r_ram_q;

  assign w_rd_col  = rd_x >> SCALE_SHIFT;
  assign w_rd_row  = rd_y >> SCALE_SHIFT;
  assign w_rd_oor  = (w_rd_col >= c_COLS9) || (w_rd_row >= c_ROWS9);
  // Out-of-range requests are parked at address 0 so the RAM index always
  // stays inside the bank; their data is forced to 0 anyway.
  assign w_rd_addr = w_rd_oor ? '0 : {w_rd_row[c_RW-1:0], w_rd_col[c_CW-1:0]};

  // Stage 1 captures the bank and the have_frame state together, so a read
  // issued before a swap is answered entirely from the old frame.
  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_zero  <= 1'b1;
      r_s1_bank  <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_zero  <= 1'b1;
    end else begin
      r_s1_valid <= rd_en;
      r_s1_zero  <= w_rd_oor || !r_have_frame;
      r_s1_bank  <= r_disp_bank;
      r_s1_addr  <= w_rd_addr;
      r_s2_valid <= r_s1_valid;
      r_s2_zero  <= r_s1_zero;
    end
  end

  // RAM: one write port into the back bank, one registered read port.
  always_ff @(posedge clk100M) begin
    if (w_we) begin
      r_mem[~r_disp_bank][w_ram_waddr] <= pix_data;
    end
    r_ram_q <= r_mem[r_s1_bank][r_s1_addr];
  end

  assign rd_valid    = r_s2_valid;
  assign rd_data     = r_s2_zero ? 8'd0 : r_ram_q;
  assign frame_ready = r_frame_ready;
  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;

endmodule
`default_nettype wire
